// File: rtl/pulse_sync_pkg.sv
// Shared types and defaults for the pulse-synchronizer transmit side.
// Holds the FSM state encoding, parameter defaults and the counter width helper.
package pulse_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GUARD  = 2'd2
    } state_e;

    localparam int N_DEF     = 8;
    localparam int HOLD_DEF  = 4;
    localparam int GUARD_DEF = 2;

    // One down-counter times both phases, so size it for the longer one.
    function automatic int cnt_width(input int hold, input int guard);
        int m;
        m = (hold > guard) ? hold : guard;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_sync_tx.sv
// Transmit side of a strobe/data clock-domain crossing: holds stb for HOLD cycles, then data
// stays stable for GUARD more; one-entry pending buffer, in_ready low while it is full or ena low.
module pulse_sync_tx
    import pulse_sync_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int HOLD  = HOLD_DEF,
    parameter int GUARD = GUARD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic [N-1:0] data_out,
    output logic         stb,
    output logic         busy
);

    localparam int CW = cnt_width(HOLD, GUARD);

    generate
        if (HOLD < 1 || GUARD < 1) begin : g_bad_param
            $error("pulse_sync_tx: HOLD and GUARD must both be >= 1");
        end
    endgenerate

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stb_q, stb_d;
    logic [N-1:0]  data_q, data_d;
    logic          pend_vld_q, pend_vld_d;
    logic [N-1:0]  pend_dat_q, pend_dat_d;
    logic          accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            stb_q      <= 1'b0;
            data_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stb_q      <= stb_d;
            data_q     <= data_d;
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stb_d      = stb_q;
        data_d     = data_q;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_STROBE;
                        stb_d   = 1'b1;
                        data_d  = in_data;
                        cnt_d   = CW'(HOLD - 1);
                    end
                end
                ST_STROBE: begin
                    if (accept) begin
                        pend_vld_d = 1'b1;
                        pend_dat_d = in_data;
                    end
                    if (cnt_q == '0) begin
                        state_d = ST_GUARD;
                        stb_d   = 1'b0;
                        cnt_d   = CW'(GUARD - 1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_GUARD: begin
                    // Last guard cycle: a buffered word wins; otherwise a same-cycle accept bypasses the buffer.
                    if (cnt_q == '0) begin
                        if (pend_vld_q || accept) begin
                            state_d    = ST_STROBE;
                            stb_d      = 1'b1;
                            data_d     = pend_vld_q ? pend_dat_q : in_data;
                            pend_vld_d = 1'b0;
                            cnt_d      = CW'(HOLD - 1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        if (accept) begin
                            pend_vld_d = 1'b1;
                            pend_dat_d = in_data;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    stb_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready = ena & ~rst & ~pend_vld_q;
        accept   = in_valid & in_ready;
        busy     = (state_q != ST_IDLE);
        stb      = stb_q;
        data_out = data_q;
    end

endmodule

// File: tb/tb_pulse_sync_tx.sv
// Bench for pulse_sync_tx: per-cycle vector table for the corner cases, then random traffic,
// with a strobe-edge receiver that pops an in-order queue of accepted words.
module tb_pulse_sync_tx;

    localparam int N     = 8;
    localparam int HOLD  = 4;
    localparam int GUARD = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         in_ready;
    logic [N-1:0] data_out;
    logic         stb;
    logic         busy;

    pulse_sync_tx #(.N(N), .HOLD(HOLD), .GUARD(GUARD)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .data_out (data_out),
        .stb      (stb),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ena, vld;
        logic [7:0] dat;
        logic       rdy, stb, busy;
        logic [7:0] dout;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         rx_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic v, input logic [7:0] d,
                       input logic rdy, input logic s, input logic b, input logic [7:0] o,
                       input int reps);
        vec_t x;
        x.rst = r; x.ena = e; x.vld = v; x.dat = d;
        x.rdy = rdy; x.stb = s; x.busy = b; x.dout = o;
        for (int i = 0; i < reps; i++) tbl.push_back(x);
    endtask

    // Receiver model: captures on strobe rise, checks order, stability, strobe width and spacing.
    logic       stb_prev = 1'b0;
    logic [7:0] last_rx = '0;
    int         hi_cnt = 0;
    int         en_since = 0;
    logic       saw_idle = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hi_cnt   = 0;
            saw_idle = 1'b1;
        end else begin
            if (stb && !stb_prev) begin
                if (exp_q.size() == 0) begin
                    check("rx_unexpected_strobe", {24'd0, data_out}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
                end
                if (!saw_idle) check("rise_spacing", en_since, HOLD + GUARD);
                rx_cnt++;
                last_rx  = data_out;
                hi_cnt   = 0;
                en_since = 0;
                saw_idle = 1'b0;
            end else if (busy) begin
                check("data_stable", {24'd0, data_out}, {24'd0, last_rx});
            end
            if (stb_prev && !stb) check("stb_width", hi_cnt, HOLD);
            if (!busy) saw_idle = 1'b1;
            if (ena && stb) hi_cnt++;
            if (ena) en_since++;
            if (ena && in_valid && in_ready) exp_q.push_back(in_data);
        end
        stb_prev = stb;
    end

    initial begin
        int sent;
        int cyc;

        // reset held
        add(1,1,1,8'hFF, 0,0,0,8'h00, 2);
        // single word
        add(0,1,1,8'hA5, 1,0,0,8'h00, 1);
        add(0,1,0,8'h00, 1,1,1,8'hA5, 4);
        add(0,1,0,8'h00, 1,0,1,8'hA5, 2);
        add(0,1,0,8'h00, 1,0,0,8'hA5, 1);
        // back-to-back via pending buffer
        add(0,1,1,8'h11, 1,0,0,8'hA5, 1);
        add(0,1,1,8'h22, 1,1,1,8'h11, 1);
        add(0,1,1,8'h22, 0,1,1,8'h11, 3);
        add(0,1,1,8'h22, 0,0,1,8'h11, 2);
        add(0,1,0,8'h00, 1,1,1,8'h22, 4);
        add(0,1,0,8'h00, 1,0,1,8'h22, 2);
        add(0,1,0,8'h00, 1,0,0,8'h22, 1);
        // bypass in last guard cycle
        add(0,1,1,8'h33, 1,0,0,8'h22, 1);
        add(0,1,0,8'h00, 1,1,1,8'h33, 4);
        add(0,1,0,8'h00, 1,0,1,8'h33, 1);
        add(0,1,1,8'h44, 1,0,1,8'h33, 1);
        add(0,1,0,8'h00, 1,1,1,8'h44, 4);
        add(0,1,0,8'h00, 1,0,1,8'h44, 2);
        add(0,1,0,8'h00, 1,0,0,8'h44, 1);
        // enable dropped during strobe
        add(0,1,1,8'h66, 1,0,0,8'h44, 1);
        add(0,1,0,8'h00, 1,1,1,8'h66, 1);
        add(0,0,1,8'h77, 0,1,1,8'h66, 3);
        add(0,1,0,8'h00, 1,1,1,8'h66, 3);
        add(0,1,0,8'h00, 1,0,1,8'h66, 2);
        add(0,1,0,8'h00, 1,0,0,8'h66, 1);
        // reset during guard with a pending word
        add(0,1,1,8'h77, 1,0,0,8'h66, 1);
        add(0,1,1,8'h55, 1,1,1,8'h77, 1);
        add(0,1,0,8'h00, 0,1,1,8'h77, 3);
        add(0,1,0,8'h00, 0,0,1,8'h77, 1);
        add(1,1,0,8'h00, 0,0,0,8'h00, 1);
        add(0,1,0,8'h00, 1,0,0,8'h00, 1);
        add(0,1,1,8'h99, 1,0,0,8'h00, 1);
        add(0,1,0,8'h00, 1,1,1,8'h99, 4);
        add(0,1,0,8'h00, 1,0,1,8'h99, 2);
        add(0,1,0,8'h00, 1,0,0,8'h99, 1);

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            rst = tbl[k].rst; ena = tbl[k].ena; in_valid = tbl[k].vld; in_data = tbl[k].dat;
            #1;
            check($sformatf("v%0d.in_ready", k), {31'd0, in_ready}, {31'd0, tbl[k].rdy});
            check($sformatf("v%0d.stb", k),      {31'd0, stb},      {31'd0, tbl[k].stb});
            check($sformatf("v%0d.busy", k),     {31'd0, busy},     {31'd0, tbl[k].busy});
            check($sformatf("v%0d.data_out", k), {24'd0, data_out}, {24'd0, tbl[k].dout});
        end

        // random traffic: 100 words, random enable and valid
        sent = 0;
        cyc  = 0;
        while (sent < 100 && cyc < 5000) begin
            @(posedge clk);
            #1;
            ena      = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 8'($urandom);
            #1;
            if (ena && in_valid && in_ready) sent++;
            cyc++;
        end
        @(posedge clk);
        #1;
        ena      = 1'b1;
        in_valid = 1'b0;
        cyc      = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        check("rand_sent", sent, 100);
        check("rand_drain_queue", exp_q.size(), 0);
        check("rand_drain_idle", {31'd0, busy}, 32'd0);
        check("rx_total", rx_cnt, 108);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_sync_tx.md
PULSE_SYNC_TX -- requirements
Module: pulse_sync_tx

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning data bus width in bits.
REQ-002 The block SHALL have parameter HOLD, default 4, meaning the number of cycles stb is held high per word (legal range HOLD>=1).
REQ-003 The block SHALL have parameter GUARD, default 2, meaning the number of cycles data_out is held stable after stb falls (legal range GUARD>=1).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 ena  input  1  design enable; when low, all state SHALL freeze and in_ready SHALL be 0.
REQ-008 in_valid  input  1  the upstream word is valid.
REQ-009 in_data  input  N  the upstream word.
REQ-010 in_ready  output  1  the block can accept a word this cycle.
REQ-011 data_out  output  N  registered word presented to the downstream synchronizer.
REQ-012 stb  output  1  registered strobe to the downstream synchronizer.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The block SHALL accept a word in every cycle where in_valid, in_ready and ena are all 1, and in no other cycle.
REQ-015 The FSM SHALL have three states: IDLE, STROBE and GUARD.
REQ-016 In IDLE, an accepted word SHALL load data_out and set stb=1 on the next edge; the FSM SHALL then enter STROBE (latency 1 cycle).
REQ-017 STROBE SHALL last exactly HOLD cycles with stb=1, then move to GUARD with stb=0.
REQ-018 GUARD SHALL last exactly GUARD cycles with stb=0.
REQ-019 data_out SHALL NOT change from the load edge until the end of GUARD.
REQ-020 The block SHALL contain a 1-entry pending buffer; in_ready SHALL equal ena AND (pending buffer empty).
REQ-021 A word accepted in STROBE or GUARD SHALL be written into the pending buffer.
REQ-022 At the end of the last GUARD cycle, if the pending buffer is full or a word is accepted in that same cycle, that word SHALL load data_out with stb=1; the FSM SHALL re-enter STROBE, the pending buffer SHALL be marked empty, and the buffer SHALL be bypassed for a same-cycle accept.
REQ-023 At the end of the last GUARD cycle with no word available, the FSM SHALL return to IDLE.
REQ-024 Back-to-back words SHALL therefore be spaced exactly HOLD+GUARD cycles apart, strobe-rise to strobe-rise.
REQ-025 A single down-counter SHALL time both phases; its width SHALL be clog2(max(HOLD,GUARD)+1).
REQ-026 Words SHALL never be dropped, duplicated or reordered.

Reset
REQ-027 While rst is high: state=IDLE, stb=0, data_out=0, busy=0, pending buffer empty, counter=0.
REQ-028 in_ready SHALL be 0 while rst is high.
REQ-029 An assertion of rst mid-STROBE or mid-GUARD SHALL abort the transfer and discard the pending word.
REQ-030 After release of rst, the first accepted word SHALL follow REQ-016.

Structure
REQ-031 The FSM state enum and the parameter defaults SHALL reside in the shared package pulse_sync_pkg.
REQ-032 No sub-module SHALL be used; the counter and FSM SHALL be inline.
REQ-033 An elaboration-time check SHALL reject HOLD<1 or GUARD<1.
REQ-034 The outputs stb and data_out SHALL feed pulse_sync's stb and data_in directly.

Verification
REQ-035 Single word (N=8, HOLD=4, GUARD=2): accept 0xA5 at cycle 0 -> stb high in cycles 1-4, low in cycles 5-6, data_out=0xA5 in cycles 1-6, busy falls at cycle 7.
REQ-036 Back-to-back: 0x11 at cycle 0, 0x22 held valid from cycle 1 -> 0x22 accepted at cycle 1 into pending, in_ready=0 in cycles 2-6, second stb rises at cycle 7.
REQ-037 Bypass: 0x33 idle-accepted, 0x44 presented only in the last GUARD cycle -> 0x44 loaded directly, stb re-rises with no IDLE cycle.
REQ-038 ena low for 3 cycles during STROBE -> stb width extends to exactly 4 enabled cycles and data_out is unchanged.
REQ-039 rst pulse during GUARD with pending=0x55 -> stb=0, data_out=0x00, busy=0, and 0x55 is never emitted.
REQ-040 End-to-end with pulse_sync downstream: 100 random words -> the received sequence matches the sent sequence exactly.
